// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache refill controller.
package icache_refill_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOOKUP   = 3'd1,
      ST_MISS_REQ = 3'd2,
      ST_REFILL   = 3'd3,
      ST_RESPOND  = 3'd4
   } state_e;

   localparam int unsigned BYTE_OFF_W = 2;

   // Width of a select field; a 1-entry space still needs a 1-bit signal.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icache_tag_data_array.sv
// Valid flops, tag RAM and word-addressed data RAM for the instruction cache.
// Synchronous read of one word plus tag/valid; word write, tag write sets valid, flash clear.
module icache_tag_data_array
   import icache_refill_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned LINE_WORDS = 2,
   parameter int unsigned NUM_LINES  = 64,
   parameter int unsigned TAG_W      = 23,
   parameter int unsigned IDX_W      = 6,
   parameter int unsigned SEL_W      = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_rd_en,
   input  logic [IDX_W-1:0]  i_rd_idx,
   input  logic [SEL_W-1:0]  i_rd_sel,
   output logic              o_rd_valid,
   output logic [TAG_W-1:0]  o_rd_tag,
   output logic [DATA_W-1:0] o_rd_word,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [SEL_W-1:0]  i_wr_sel,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_tag_we,
   input  logic [TAG_W-1:0]  i_wr_tag,
   input  logic              i_flash_clr
);

   logic [NUM_LINES-1:0] r_valid;
   logic [TAG_W-1:0]     r_tag  [NUM_LINES];
   logic [DATA_W-1:0]    r_data [NUM_LINES][LINE_WORDS];
   logic                 r_rd_valid;
   logic [TAG_W-1:0]     r_rd_tag;
   logic [DATA_W-1:0]    r_rd_word;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= '0;
      end else if (i_flash_clr) begin
         r_valid <= '0;
      end else if (i_tag_we) begin
         r_valid[i_wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_data[i_wr_idx][i_wr_sel] <= i_wr_data;
      end
      if (i_tag_we) begin
         r_tag[i_wr_idx] <= i_wr_tag;
      end
   end

   // A flush in the same cycle as the read must make the lookup see an empty cache.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_valid <= 1'b0;
         r_rd_tag   <= '0;
         r_rd_word  <= '0;
      end else if (i_rd_en) begin
         r_rd_valid <= r_valid[i_rd_idx] & ~i_flash_clr;
         r_rd_tag   <= r_tag[i_rd_idx];
         r_rd_word  <= r_data[i_rd_idx][i_rd_sel];
      end
   end

   assign o_rd_valid = r_rd_valid;
   assign o_rd_tag   = r_rd_tag;
   assign o_rd_word  = r_rd_word;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache controller: handshaked fetch port, burst line refill,
// flush (immediate in IDLE, deferred otherwise) and saturating hit/miss counters.
//
//   state       | meaning
//   ST_IDLE     | waiting for i_cpu_req; applies pending/immediate flush
//   ST_LOOKUP   | array output valid; hit/miss decision, counters update
//   ST_MISS_REQ | o_mem_req held with line base address until i_mem_gnt
//   ST_REFILL   | one word written per i_mem_rvalid; last beat writes tag+valid
//   ST_RESPOND  | o_cpu_ready pulse with o_cpu_instr
module icache_refill_ctrl
   import icache_refill_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned LINE_WORDS = 2,
   parameter int unsigned NUM_LINES  = 64,
   parameter int unsigned CNT_W      = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_cpu_req,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   output logic              o_cpu_ready,
   output logic [DATA_W-1:0] o_cpu_instr,
   output logic              o_cache_miss,
   input  logic              i_flush,
   output logic              o_mem_req,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic              i_mem_gnt,
   input  logic              i_mem_rvalid,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [CNT_W-1:0]  o_hit_count,
   output logic [CNT_W-1:0]  o_miss_count
);

   localparam int unsigned WSEL_W  = $clog2(LINE_WORDS);
   localparam int unsigned SEL_W   = sel_width(LINE_WORDS);
   localparam int unsigned IDX_W   = $clog2(NUM_LINES);
   localparam int unsigned LINE_SH = BYTE_OFF_W + WSEL_W;
   localparam int unsigned TAG_SH  = LINE_SH + IDX_W;
   localparam int unsigned TAG_W   = ADDR_W - TAG_SH;
   localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_SH) - ADDR_W'(1));
   localparam logic [ADDR_W-1:0] SEL_MASK  = ADDR_W'(LINE_WORDS - 1);
   localparam logic [SEL_W-1:0]  LAST_BEAT = SEL_W'(LINE_WORDS - 1);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [SEL_W-1:0]    r_beat;
   logic [DATA_W-1:0]   r_instr;
   logic                r_flush_pend;
   logic [CNT_W-1:0]    r_hit_cnt;
   logic [CNT_W-1:0]    r_miss_cnt;

   logic [SEL_W-1:0]    w_in_sel;
   logic [IDX_W-1:0]    w_in_idx;
   logic [SEL_W-1:0]    w_q_sel;
   logic [IDX_W-1:0]    w_q_idx;
   logic [TAG_W-1:0]    w_q_tag;
   logic                w_rd_en;
   logic                w_wr_en;
   logic                w_tag_we;
   logic                w_flash_clr;
   logic                w_hit;
   logic                w_miss;
   logic                w_beat_last;
   logic                w_rd_valid;
   logic [TAG_W-1:0]    w_rd_tag;
   logic [DATA_W-1:0]   w_rd_word;

   assign w_in_sel    = SEL_W'((i_cpu_addr >> BYTE_OFF_W) & SEL_MASK);
   assign w_in_idx    = IDX_W'(i_cpu_addr >> LINE_SH);
   assign w_q_sel     = SEL_W'((r_addr >> BYTE_OFF_W) & SEL_MASK);
   assign w_q_idx     = IDX_W'(r_addr >> LINE_SH);
   assign w_q_tag     = TAG_W'(r_addr >> TAG_SH);
   assign w_beat_last = (r_beat == LAST_BEAT);

   icache_tag_data_array #(
      .DATA_W     (DATA_W),
      .LINE_WORDS (LINE_WORDS),
      .NUM_LINES  (NUM_LINES),
      .TAG_W      (TAG_W),
      .IDX_W      (IDX_W),
      .SEL_W      (SEL_W)
   ) u_array (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_rd_en     (w_rd_en),
      .i_rd_idx    (w_in_idx),
      .i_rd_sel    (w_in_sel),
      .o_rd_valid  (w_rd_valid),
      .o_rd_tag    (w_rd_tag),
      .o_rd_word   (w_rd_word),
      .i_wr_en     (w_wr_en),
      .i_wr_idx    (w_q_idx),
      .i_wr_sel    (r_beat),
      .i_wr_data   (i_mem_rdata),
      .i_tag_we    (w_tag_we),
      .i_wr_tag    (w_q_tag),
      .i_flash_clr (w_flash_clr)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      w_wr_en     = 1'b0;
      w_tag_we    = 1'b0;
      w_flash_clr = 1'b0;
      w_hit       = 1'b0;
      w_miss      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_flash_clr = i_flush | r_flush_pend;
            if (i_cpu_req) begin
               w_rd_en     = 1'b1;
               w_state_nxt = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            w_hit       = w_rd_valid && (w_rd_tag == w_q_tag);
            w_miss      = ~w_hit;
            w_state_nxt = w_hit ? ST_RESPOND : ST_MISS_REQ;
         end
         ST_MISS_REQ: begin
            if (i_mem_gnt) begin
               w_state_nxt = ST_REFILL;
            end
         end
         ST_REFILL: begin
            if (i_mem_rvalid) begin
               w_wr_en = 1'b1;
               if (w_beat_last) begin
                  w_tag_we    = 1'b1;
                  w_state_nxt = ST_RESPOND;
               end
            end
         end
         ST_RESPOND: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr  <= '0;
         r_beat  <= '0;
         r_instr <= '0;
      end else begin
         if (w_rd_en) begin
            r_addr <= i_cpu_addr;
         end
         if (w_hit) begin
            r_instr <= w_rd_word;
         end
         // The requested word is picked off the burst as it streams past.
         if (w_wr_en) begin
            r_beat <= w_beat_last ? '0 : r_beat + SEL_W'(1);
            if (r_beat == w_q_sel) begin
               r_instr <= i_mem_rdata;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_flush_pend <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         r_flush_pend <= 1'b0;
      end else if (i_flush) begin
         r_flush_pend <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_hit && (r_hit_cnt != '1)) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
         end
         if (w_miss && (r_miss_cnt != '1)) begin
            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
         end
      end
   end

   assign o_cpu_ready  = (r_state == ST_RESPOND);
   assign o_cpu_instr  = r_instr;
   assign o_cache_miss = w_miss;
   assign o_mem_req    = (r_state == ST_MISS_REQ);
   assign o_mem_addr   = (r_state == ST_MISS_REQ) ? (r_addr & LINE_MASK) : '0;
   assign o_hit_count  = r_hit_cnt;
   assign o_miss_count = r_miss_cnt;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: fetch table with a small memory/counter model,
// plus hand sequences for reset mid-refill and counter saturation.
module tb_icache_refill_ctrl;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic        cpu_ready;
   logic [31:0] cpu_instr;
   logic        cache_miss;
   logic        flush = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [CNT_W-1:0] hit_count;
   logic [CNT_W-1:0] miss_count;

   int n_pass  = 0;
   int n_total = 0;
   int m_hits  = 0;
   int m_miss  = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] b0;
      logic [31:0] b1;
      int          flush_mode;
      bit          exp_miss;
      logic [31:0] exp_instr;
      string       name;
   } vec_t;

   vec_t tbl[$];

   icache_refill_ctrl #(
      .ADDR_W(32), .DATA_W(32), .LINE_WORDS(2), .NUM_LINES(64), .CNT_W(CNT_W)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_cpu_req    (cpu_req),
      .i_cpu_addr   (cpu_addr),
      .o_cpu_ready  (cpu_ready),
      .o_cpu_instr  (cpu_instr),
      .o_cache_miss (cache_miss),
      .i_flush      (flush),
      .o_mem_req    (mem_req),
      .o_mem_addr   (mem_addr),
      .i_mem_gnt    (mem_gnt),
      .i_mem_rvalid (mem_rvalid),
      .i_mem_rdata  (mem_rdata),
      .o_hit_count  (hit_count),
      .o_miss_count (miss_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic add(input logic [31:0] a, input logic [31:0] b0, input logic [31:0] b1,
                      input int fm, input bit em, input logic [31:0] ei, input string nm);
      vec_t v;
      v.addr = a; v.b0 = b0; v.b1 = b1; v.flush_mode = fm;
      v.exp_miss = em; v.exp_instr = ei; v.name = nm;
      tbl.push_back(v);
   endtask

   // flush_mode: 0 none, 1 flush alongside the request in IDLE, 2 flush during first refill beat
   task automatic fetch(input logic [31:0] addr, input logic [31:0] b0, input logic [31:0] b1,
                        input int flush_mode, input bit exp_miss, input logic [31:0] exp_instr,
                        input string nm);
      bit          saw_miss = 0;
      bit          saw_req = 0;
      bit          granted = 0;
      bit          done = 0;
      int          beats = 0;
      int          lat = 0;
      int          last_lat = -10;
      logic [31:0] req_addr = '0;
      logic [31:0] instr = '0;
      logic [31:0] b [2];
      b[0] = b0;
      b[1] = b1;
      @(posedge clk); #1;
      cpu_req = 1'b1;
      cpu_addr = addr;
      flush = (flush_mode == 1);
      @(posedge clk); #1;
      cpu_req = 1'b0;
      flush = 1'b0;
      lat = 1;
      for (int c = 0; c < 40 && !done; c++) begin
         mem_gnt = 1'b0;
         mem_rvalid = 1'b0;
         mem_rdata = '0;
         flush = 1'b0;
         if (cpu_ready) begin
            done = 1;
            instr = cpu_instr;
         end else begin
            if (cache_miss) saw_miss = 1;
            if (mem_req && !granted) begin
               saw_req = 1;
               req_addr = mem_addr;
               mem_gnt = 1'b1;
               granted = 1;
            end else if (granted && beats < 2) begin
               mem_rvalid = 1'b1;
               mem_rdata = b[beats];
               if (beats == 0 && flush_mode == 2) flush = 1'b1;
               beats++;
               if (beats == 2) last_lat = lat;
            end
            @(posedge clk); #1;
            lat++;
         end
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      flush = 1'b0;
      if (!done) begin
         n_total++;
         $display("FAIL %s timeout: no cpu_ready within 40 cycles", nm);
      end else begin
         check({nm, " cache_miss"}, 32'(saw_miss), 32'(exp_miss));
         check({nm, " mem_req"}, 32'(saw_req), 32'(exp_miss));
         if (exp_miss) begin
            check({nm, " mem_addr"}, req_addr, addr & 32'hFFFF_FFF8);
            check({nm, " miss latency"}, 32'(lat - last_lat), 32'd1);
         end else begin
            check({nm, " hit latency"}, 32'(lat), 32'd2);
         end
         check({nm, " instr"}, instr, exp_instr);
      end
      if (exp_miss) begin
         if (m_miss < CNT_MAX) m_miss++;
      end else begin
         if (m_hits < CNT_MAX) m_hits++;
      end
      @(posedge clk); #1;
      check({nm, " ready pulse"}, 32'(cpu_ready), 32'd0);
      check({nm, " hit_count"}, 32'(hit_count), 32'(m_hits));
      check({nm, " miss_count"}, 32'(miss_count), 32'(m_miss));
   endtask

   initial begin
      add(32'h100, 32'hA,  32'hB,  0, 1'b1, 32'hA,  "t1_miss_100");
      add(32'h104, 32'h0,  32'h0,  0, 1'b0, 32'hB,  "t2_hit_104");
      add(32'h100, 32'h0,  32'h0,  0, 1'b0, 32'hA,  "t3_hit_100");
      add(32'h300, 32'h30, 32'h31, 0, 1'b1, 32'h30, "t3_evict_300");
      add(32'h104, 32'hA,  32'hB,  0, 1'b1, 32'hB,  "t3_refetch_104");
      add(32'h304, 32'h30, 32'h31, 0, 1'b1, 32'h31, "t3_refetch_304");
      add(32'h300, 32'h0,  32'h0,  0, 1'b0, 32'h30, "hit_300");
      add(32'h008, 32'h80, 32'h81, 0, 1'b1, 32'h80, "miss_008");
      add(32'h00C, 32'h0,  32'h0,  0, 1'b0, 32'h81, "hit_00c");
      add(32'h304, 32'h0,  32'h0,  0, 1'b0, 32'h31, "hit_304");
      add(32'h010, 32'hC0, 32'hC1, 2, 1'b1, 32'hC0, "t4_flush_in_refill");
      add(32'h014, 32'hC0, 32'hC1, 0, 1'b1, 32'hC1, "t4_after_flush");
      add(32'h300, 32'h30, 32'h31, 0, 1'b1, 32'h30, "t4_other_line_flushed");
      add(32'h308, 32'h50, 32'h51, 0, 1'b1, 32'h50, "miss_308");
      add(32'h30C, 32'h0,  32'h0,  0, 1'b0, 32'h51, "hit_30c");
      add(32'h30C, 32'h50, 32'h51, 1, 1'b1, 32'h51, "flush_with_req");
      add(32'h308, 32'h0,  32'h0,  0, 1'b0, 32'h50, "hit_after_idle_flush");

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst cpu_ready", 32'(cpu_ready), 32'd0);
      check("rst cpu_instr", cpu_instr, 32'd0);
      check("rst cache_miss", 32'(cache_miss), 32'd0);
      check("rst mem_req", 32'(mem_req), 32'd0);
      check("rst mem_addr", mem_addr, 32'd0);
      check("rst hit_count", 32'(hit_count), 32'd0);
      check("rst miss_count", 32'(miss_count), 32'd0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         fetch(tbl[i].addr, tbl[i].b0, tbl[i].b1, tbl[i].flush_mode,
               tbl[i].exp_miss, tbl[i].exp_instr, tbl[i].name);
      end

      // Reset in the middle of a burst, then stray beats while idle.
      @(posedge clk); #1;
      cpu_req = 1'b1;
      cpu_addr = 32'h400;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      for (int c = 0; c < 10 && !mem_req; c++) begin
         @(posedge clk); #1;
      end
      check("t5 mem_req before reset", 32'(mem_req), 32'd1);
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hDEAD;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t5 mem_req in reset", 32'(mem_req), 32'd0);
      check("t5 cpu_ready in reset", 32'(cpu_ready), 32'd0);
      check("t5 mem_addr in reset", mem_addr, 32'd0);
      check("t5 miss_count in reset", 32'(miss_count), 32'd0);
      check("t5 hit_count in reset", 32'(hit_count), 32'd0);
      m_hits = 0;
      m_miss = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hBEEF;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("t5 stray beat ready", 32'(cpu_ready), 32'd0);
         check("t5 stray beat mem_req", 32'(mem_req), 32'd0);
      end
      mem_rvalid = 1'b0;
      fetch(32'h400, 32'h40, 32'h41, 0, 1'b1, 32'h40, "t5_refetch_400");
      fetch(32'h100, 32'hA,  32'hB,  0, 1'b1, 32'hA,  "t5_refetch_100");

      // Drive the miss counter past all-ones; the hit counter must stay put.
      fetch(32'h104, 32'h0, 32'h0, 0, 1'b0, 32'hB, "t6_hit");
      for (int k = 0; k < 15; k++) begin
         fetch(32'h100, 32'hA, 32'hB, 1, 1'b1, 32'hA, "t6_sat_miss");
      end
      check("t6 miss_count saturated", 32'(miss_count), 32'(CNT_MAX));
      check("t6 hit_count held", 32'(hit_count), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
